mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 45 ++++
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Two-master memory arbiter bus: master request/response pairs plus the
// memory-file side. The arbiter uses the slave modport, the requester/memory
// environment uses the master modport.
interface mem_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic [3:0]  m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_ack;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic        m1_we;
  logic [3:0]  m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_ack;
  logic [31:0] m1_rdata;

  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ldr_str_en;
  logic        mem_load_en;
  logic        mem_store_en;
  logic [31:0] mem_rdata;

  logic        busy;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output mem_addr, mem_wdata, mem_ldr_str_en, mem_load_en, mem_store_en,
    output busy
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  mem_addr, mem_wdata, mem_ldr_str_en, mem_load_en, mem_store_en,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: grants one master at a time to a 16-entry memory
// file, one access per three cycles, round-robin or m0-priority on ties.
//
// state  | meaning
// IDLE   | waiting for a request; grant chosen and request latched on exit
// ACCESS | memory enables asserted for the latched request
// RESP   | ack pulse to the granted port; last_grant updated on exit
module mem_arbiter #(
  parameter int FIXED_PRIO = 0
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  logic        grant;        // 1 = m1 holds the current grant
  logic        last_grant;   // 1 = m1 was served last
  logic        lat_we;
  logic [3:0]  lat_addr;
  logic [31:0] lat_wdata;
  logic        ack0_q;
  logic        ack1_q;
  logic [31:0] rdata0_q;
  logic [31:0] rdata1_q;
  logic        ldr_str_q;
  logic        load_q;
  logic        store_q;
  logic        busy_q;

  logic        any_req;
  logic        pick_m1;
  logic        sel_we;
  logic [3:0]  sel_addr;
  logic [31:0] sel_wdata;

  // Grant choice: lone requester wins; ties go to m0 or to the port not served last.
  always_comb begin
    any_req   = bus.m0_req | bus.m1_req;
    pick_m1   = 1'b0;
    if (bus.m1_req && !bus.m0_req) begin
      pick_m1 = 1'b1;
    end else if (bus.m1_req && bus.m0_req && FIXED_PRIO == 0) begin
      pick_m1 = ~last_grant;
    end
    sel_we    = pick_m1 ? bus.m1_we    : bus.m0_we;
    sel_addr  = pick_m1 ? bus.m1_addr  : bus.m0_addr;
    sel_wdata = pick_m1 ? bus.m1_wdata : bus.m0_wdata;
  end

  // Arbiter FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      ldr_str_q  <= 1'b0;
      load_q     <= 1'b0;
      store_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant     <= pick_m1;
            lat_we    <= sel_we;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
            ldr_str_q <= 1'b1;
            store_q   <= sel_we;
            load_q    <= ~sel_we;
            busy_q    <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          ldr_str_q <= 1'b0;
          store_q   <= 1'b0;
          load_q    <= 1'b0;
          if (!lat_we) begin
            if (grant) rdata1_q <= bus.mem_rdata;
            else       rdata0_q <= bus.mem_rdata;
          end
          ack1_q <= grant;
          ack0_q <= ~grant;
          state  <= RESP;
        end
        RESP: begin
          ack0_q     <= 1'b0;
          ack1_q     <= 1'b0;
          busy_q     <= 1'b0;
          last_grant <= grant;
          state      <= IDLE;
        end
        default: begin
          ldr_str_q <= 1'b0;
          store_q   <= 1'b0;
          load_q    <= 1'b0;
          ack0_q    <= 1'b0;
          ack1_q    <= 1'b0;
          busy_q    <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.m0_ack         = ack0_q;
  assign bus.m1_ack         = ack1_q;
  assign bus.m0_rdata       = rdata0_q;
  assign bus.m1_rdata       = rdata1_q;
  assign bus.mem_addr       = lat_addr;
  assign bus.mem_wdata      = lat_wdata;
  assign bus.mem_ldr_str_en = ldr_str_q;
  assign bus.mem_load_en    = load_q;
  assign bus.mem_store_en   = store_q;
  assign bus.busy           = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios plus randomized
// two-master traffic against a reference memory, and an m0-priority instance.
module tb_mem_arbiter;

  typedef struct packed {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  logic clk;
  logic rst;

  mem_arbiter_if bus ();
  mem_arbiter_if bus_fp ();

  mem_arbiter #(.FIXED_PRIO(0)) dut    (.clk(clk), .rst(rst), .bus(bus));
  mem_arbiter #(.FIXED_PRIO(1)) dut_fp (.clk(clk), .rst(rst), .bus(bus_fp));

  logic [31:0] tb_mem  [16];
  logic [31:0] ref_mem [16];
  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        mon_e;
  logic [31:0] prev0 = '0;
  logic [31:0] prev1 = '0;
  int          st_cnt = 0;
  int          n_vec = 0;
  int          n_err = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // memory file environment for the round-robin instance
  assign bus.mem_rdata    = tb_mem[bus.mem_addr];
  assign bus_fp.mem_rdata = 32'hC0DE_0000 | {28'd0, bus_fp.mem_addr};

  always @(posedge clk) begin
    if (bus.mem_store_en) tb_mem[bus.mem_addr] <= bus.mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input int p, input logic req, input logic we,
                       input logic [3:0] a, input logic [31:0] d);
    if (p == 0) begin
      bus.m0_req = req; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d;
    end else begin
      bus.m1_req = req; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d;
    end
  endtask

  function automatic logic ack_of(input int p);
    return (p == 0) ? bus.m0_ack : bus.m1_ack;
  endfunction

  // One transaction: issue, push expectation, wait (bounded) for ack, drop req.
  task automatic do_txn(input int p, input logic we, input logic [3:0] a,
                        input logic [31:0] d, input bit scramble,
                        input logic [3:0] alt, output int lat);
    exp_t e;
    @(negedge clk);
    e.we    = we;
    e.addr  = a;
    e.wdata = d;
    if (we) begin
      ref_mem[a] = d;
      e.rdata    = '0;
    end else begin
      e.rdata = ref_mem[a];
    end
    if (p == 0) q0.push_back(e);
    else        q1.push_back(e);
    drive(p, 1'b1, we, a, d);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (scramble && lat == 1) drive(p, 1'b1, ~we, alt, ~d);
    end while (!ack_of(p) && lat < 20);
    if (!ack_of(p)) chk("ack_timeout", 32'(lat), 32'd0);
    drive(p, 1'b0, we, a, d);
  endtask

  // Monitor: pops expectations on acks and checks every memory access.
  always @(negedge clk) begin
    if (!rst) begin
      q0.delete();
      q1.delete();
      prev0 = '0;
      prev1 = '0;
    end else begin
      if (bus.mem_store_en) st_cnt++;
      if (bus.mem_ldr_str_en) begin
        chk("enable_exclusive", {31'd0, bus.mem_store_en ^ bus.mem_load_en}, 32'd1);
        chk("access_matches_pending",
            {31'd0, ((q0.size() > 0 && q0[0].we == bus.mem_store_en && q0[0].addr == bus.mem_addr &&
                      (!bus.mem_store_en || q0[0].wdata == bus.mem_wdata)) ||
                     (q1.size() > 0 && q1[0].we == bus.mem_store_en && q1[0].addr == bus.mem_addr &&
                      (!bus.mem_store_en || q1[0].wdata == bus.mem_wdata)))}, 32'd1);
      end
      if (bus.m0_ack | bus.m1_ack) begin
        chk("ack_onehot", {31'd0, bus.m0_ack & bus.m1_ack}, 32'd0);
        chk("busy_during_ack", {31'd0, bus.busy}, 32'd1);
      end
      if (bus.m0_ack) begin
        if (q0.size() == 0) chk("m0_ack_unexpected", 32'd1, 32'd0);
        else begin
          mon_e = q0.pop_front();
          if (!mon_e.we) prev0 = mon_e.rdata;
        end
      end
      if (bus.m1_ack) begin
        if (q1.size() == 0) chk("m1_ack_unexpected", 32'd1, 32'd0);
        else begin
          mon_e = q1.pop_front();
          if (!mon_e.we) prev1 = mon_e.rdata;
        end
      end
      chk("m0_rdata", bus.m0_rdata, prev0);
      chk("m1_rdata", bus.m1_rdata, prev1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat0, lat1, s0, a0, a1, n;
    for (int i = 0; i < 16; i++) begin
      tb_mem[i]  = '0;
      ref_mem[i] = '0;
    end
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 4'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 4'd0, 32'd0);
    bus_fp.m0_req = 1'b0; bus_fp.m0_we = 1'b0; bus_fp.m0_addr = '0; bus_fp.m0_wdata = '0;
    bus_fp.m1_req = 1'b0; bus_fp.m1_we = 1'b0; bus_fp.m1_addr = '0; bus_fp.m1_wdata = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_ldr_str_en", {31'd0, bus.mem_ldr_str_en}, 32'd0);
    chk("rst_acks", {30'd0, bus.m0_ack, bus.m1_ack}, 32'd0);
    chk("rst_mem_addr", {28'd0, bus.mem_addr}, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_m0_rdata", bus.m0_rdata, 32'd0);
    #2 rst = 1'b1;

    // simultaneous loads: m0 first, m1 three cycles later, twice
    for (int k = 0; k < 2; k++) begin
      fork
        do_txn(0, 1'b0, 4'd1, 32'd0, 1'b0, 4'd0, lat0);
        do_txn(1, 1'b0, 4'd9, 32'd0, 1'b0, 4'd0, lat1);
      join
      chk("tie_m0_latency", 32'(lat0), 32'd2);
      chk("tie_m1_latency", 32'(lat1), 32'd5);
    end

    // m0 store then load at address 3
    s0 = st_cnt;
    do_txn(0, 1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, lat);
    chk("store_en_cycles", 32'(st_cnt - s0), 32'd1);
    chk("store_latency", 32'(lat), 32'd2);
    do_txn(0, 1'b0, 4'd3, 32'd0, 1'b0, 4'd0, lat);
    chk("load_latency", 32'(lat), 32'd2);
    chk("load_m0_rdata", bus.m0_rdata, 32'hDEADBEEF);
    chk("load_m1_rdata_untouched", bus.m1_rdata, 32'd0);

    // request fields changed during ACCESS are ignored
    do_txn(1, 1'b1, 4'd15, 32'h1, 1'b1, 4'd7, lat);
    chk("late_change_mem15", tb_mem[15], 32'h1);
    chk("late_change_mem7", tb_mem[7], 32'h0);
    repeat (3) @(negedge clk);
    chk("mem_addr_held", {28'd0, bus.mem_addr}, 32'd15);
    chk("mem_wdata_held", bus.mem_wdata, 32'h1);

    // reset during ACCESS aborts the access
    @(negedge clk);
    mon_e.we = 1'b0; mon_e.addr = 4'd5; mon_e.wdata = '0; mon_e.rdata = ref_mem[5];
    q0.push_back(mon_e);
    drive(0, 1'b1, 1'b0, 4'd5, 32'd0);
    @(posedge clk);
    #1 chk("abort_in_access", {31'd0, bus.mem_ldr_str_en}, 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("abort_enables", {29'd0, bus.mem_ldr_str_en, bus.mem_load_en, bus.mem_store_en}, 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_m0_rdata", bus.m0_rdata, 32'd0);
    chk("abort_m1_rdata", bus.m1_rdata, 32'd0);
    drive(0, 1'b0, 1'b0, 4'd0, 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_ack", {30'd0, bus.m0_ack, bus.m1_ack}, 32'd0);
    end
    #2 rst = 1'b1;
    do_txn(1, 1'b0, 4'd15, 32'd0, 1'b0, 4'd0, lat);
    chk("post_reset_latency", 32'(lat), 32'd2);
    chk("post_reset_m1_rdata", bus.m1_rdata, 32'h1);

    // randomized two-master traffic, disjoint address halves
    fork
      for (int t = 0; t < 30; t++) begin
        int l;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        do_txn(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), $urandom, 1'b0, 4'd0, l);
        chk("rand_m0_latency_le5", {31'd0, l <= 5}, 32'd1);
      end
      for (int t = 0; t < 30; t++) begin
        int l;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        do_txn(1, 1'($urandom_range(0, 1)), 4'(8 + $urandom_range(0, 7)), $urandom, 1'b0, 4'd0, l);
        chk("rand_m1_latency_le5", {31'd0, l <= 5}, 32'd1);
      end
    join

    // fixed priority: both hold requests, m0 wins all four ties
    @(negedge clk);
    bus_fp.m0_req = 1'b1; bus_fp.m0_addr = 4'd4;
    bus_fp.m1_req = 1'b1; bus_fp.m1_addr = 4'd6;
    a0 = 0; a1 = 0; n = 0;
    while (a0 + a1 < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if (bus_fp.m0_ack) a0++;
      if (bus_fp.m1_ack) a1++;
    end
    chk("fp_m0_acks", 32'(a0), 32'd4);
    chk("fp_m1_acks", 32'(a1), 32'd0);
    chk("fp_m0_rdata", bus_fp.m0_rdata, 32'hC0DE0004);
    bus_fp.m0_req = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_fp.m1_ack && n < 20);
    chk("fp_loser_latency", 32'(n), 32'd3);
    chk("fp_m1_rdata", bus_fp.m1_rdata, 32'hC0DE0006);
    bus_fp.m1_req = 1'b0;

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
